// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: load-use / branch / data-memory-wait sequencing
// for the 5-stage pipeline register enables and clears.
module pipe_hazard_ctl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MEMWAIT = 1'b1;

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       mem_stall;
  logic       load_use;
  logic       sel_rst;
  logic       sel_mem;
  logic       sel_br;
  logic       sel_lu;
  logic [7:0] ctl;

  assign state = state_q;

  assign mem_stall = !mem_ack &&
    ((state_q == RUN && mem_req) ||
     (state_q == MEMWAIT));

  assign load_use = ex_memread &&
    (ex_rt != 5'd0) &&
    (ex_rt == id_rs || ex_rt == id_rt);

  assign sel_rst = !reset;
  assign sel_mem = reset && mem_stall;
  assign sel_br  = reset && !mem_stall &&
                   ex_branch_taken;
  assign sel_lu  = reset && !mem_stall &&
                   !ex_branch_taken && load_use;

  // Decode enables/flushes by priority class
  always_comb begin
    ctl = 8'b11111_000;
    unique case (1'b1)
      sel_rst: ctl = 8'b00000_111;
      sel_mem: ctl = 8'b00001_001;
      sel_br:  ctl = 8'b11111_110;
      sel_lu:  ctl = 8'b00111_010;
      default: ctl = 8'b11111_000;
    endcase
  end

  assign {pc_en, ifid_en, idex_en,
          exmem_en, memwb_en} = ctl[7:3];
  assign {ifid_flush, idex_flush,
          memwb_flush} = ctl[2:0];

  // Next-state for the memory handshake
  always_comb begin
    state_d = state_q;
    if (state_q == RUN) begin
      if (mem_req && !mem_ack)
        state_d = MEMWAIT;
    end else begin
      if (mem_ack)
        state_d = RUN;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (clr_cnt)
      stall_cnt <= '0;
    else if (!pc_en && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb_pipe_hazard_ctl: directed + random checks of the hazard
// controller against a rule-level reference model.
module tb_pipe_hazard_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_memread, ex_branch_taken;
  logic        mem_req, mem_ack, clr_cnt;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush, state;
  logic [15:0] stall_cnt;

  logic b_pc, b_ifid, b_idex, b_exmem, b_memwb;
  logic b_ifidf, b_idexf, b_memwbf, b_state;
  logic [1:0] b_cnt;

  pipe_hazard_ctl u_dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .clr_cnt(clr_cnt),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .memwb_flush(memwb_flush),
    .state(state), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .clr_cnt(clr_cnt),
    .pc_en(b_pc), .ifid_en(b_ifid),
    .idex_en(b_idex), .exmem_en(b_exmem),
    .memwb_en(b_memwb),
    .ifid_flush(b_ifidf),
    .idex_flush(b_idexf),
    .memwb_flush(b_memwbf),
    .state(b_state), .stall_cnt(b_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  bit mw = 1'b0;
  int cnt1 = 0;
  int cnt2 = 0;
  logic [7:0] e;
  logic [25:0] g1, x1;
  logic [11:0] g2, x2;

  // Reference: what the controls must be, by rule priority
  function automatic logic [7:0] model_ctl();
    bit lu;
    lu = ex_memread && ex_rt != 0 &&
         (ex_rt == id_rs || ex_rt == id_rt);
    if (!reset) return 8'b00000_111;
    if (!mem_ack && (mw || mem_req))
      return 8'b00001_001;
    if (ex_branch_taken) return 8'b11111_110;
    if (lu) return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  function automatic logic [25:0] obs1();
    return {pc_en, ifid_en, idex_en, exmem_en,
            memwb_en, ifid_flush, idex_flush,
            memwb_flush, state, stall_cnt, 1'b0};
  endfunction

  function automatic logic [11:0] obs2();
    return {b_pc, b_ifid, b_idex, b_exmem, b_memwb,
            b_ifidf, b_idexf, b_memwbf, b_state,
            b_cnt, 1'b0};
  endfunction

  function automatic logic [25:0] exp1();
    int c;
    c = reset ? cnt1 : 0;
    return {model_ctl(), reset ? mw : 1'b0,
            16'(c), 1'b0};
  endfunction

  function automatic logic [11:0] exp2();
    int c;
    c = reset ? cnt2 : 0;
    return {model_ctl(), reset ? mw : 1'b0,
            2'(c), 1'b0};
  endfunction

  task automatic drive(input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic mr,
                       input logic [4:0] ert,
                       input logic br,
                       input logic rq,
                       input logic ak,
                       input logic cl);
    id_rs = rs; id_rt = rt; ex_memread = mr;
    ex_rt = ert; ex_branch_taken = br;
    mem_req = rq; mem_ack = ak; clr_cnt = cl;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0,
          1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and move the model with it
  task automatic tick();
    logic pce;
    pce = model_ctl()[7];
    @(posedge clk);
    if (!reset) begin
      mw = 1'b0; cnt1 = 0; cnt2 = 0;
    end else begin
      if (clr_cnt) begin
        cnt1 = 0; cnt2 = 0;
      end else if (!pce) begin
        if (cnt1 < 65535) cnt1++;
        if (cnt2 < 3) cnt2++;
      end
      mw = mw ? !mem_ack : (mem_req && !mem_ack);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0,
          1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (obs1() !== 26'b00000_111_0_0000000000000000_0) begin
        n_err++;
        $display("FAIL reset_hold got %b exp %b",
                 obs1(), 26'b00000_111_0_0000000000000000_0);
      end
      n_vec++;
      if (obs2() !== exp2()) begin
        n_err++;
        $display("FAIL reset_hold2 got %b exp %b",
                 obs2(), exp2());
      end
      tick();
    end
    reset = 1'b1;
    idle();
    @(negedge clk);
    n_vec++;
    if (obs1() !== 26'b11111_000_0_0000000000000000_0) begin
      n_err++;
      $display("FAIL reset_release got %b exp %b",
               obs1(), 26'b11111_000_0_0000000000000000_0);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd9, 1'b1, 5'd5, 1'b0,
          1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (obs1() !== exp1()) begin
      n_err++;
      $display("FAIL load_use got %b exp %b",
               obs1(), exp1());
    end
    tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (stall_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL load_use_cnt got %0d exp 1",
               stall_cnt);
    end
    drive(5'd0, 5'd9, 1'b1, 5'd0, 1'b0,
          1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (obs1() !== exp1() || !pc_en) begin
      n_err++;
      $display("FAIL load_use_r0 got %b exp %b",
               obs1(), exp1());
    end
    tick();
  endtask

  task automatic test_mem_wait();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0,
          1'b0, 1'b0, 1'b1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0,
            1'b1, c == 4, 1'b0);
      @(negedge clk);
      n_vec++;
      if (obs1() !== exp1()) begin
        n_err++;
        $display("FAIL mem_wait_c%0d got %b exp %b",
                 c, obs1(), exp1());
      end
      n_vec++;
      if (state !== (c >= 2)) begin
        n_err++;
        $display("FAIL mem_wait_state%0d got %b exp %b",
                 c, state, c >= 2);
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_vec++;
    if ({state, stall_cnt} !== {1'b0, 16'd3}) begin
      n_err++;
      $display("FAIL mem_wait_end got st=%b cnt=%0d exp st=0 cnt=3",
               state, stall_cnt);
    end
    tick();
  endtask

  task automatic test_zero_wait();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0,
          1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (obs1() !== exp1() || !pc_en) begin
      n_err++;
      $display("FAIL zero_wait got %b exp %b",
               obs1(), exp1());
    end
    tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (state !== 1'b0) begin
      n_err++;
      $display("FAIL zero_wait_state got %b exp 0",
               state);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    drive(5'd7, 5'd0, 1'b1, 5'd7, 1'b1,
          1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (obs1() !== exp1()) begin
      n_err++;
      $display("FAIL br_vs_lu got %b exp %b",
               obs1(), exp1());
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b1,
            1'b1, c == 2, 1'b0);
      @(negedge clk);
      n_vec++;
      if (obs1() !== exp1()) begin
        n_err++;
        $display("FAIL br_in_wait%0d got %b exp %b",
                 c, obs1(), exp1());
      end
      tick();
    end
  endtask

  task automatic test_counter();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0,
          1'b0, 1'b0, 1'b1);
    tick();
    drive(5'd4, 5'd6, 1'b1, 5'd6, 1'b0,
          1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (b_cnt !== 2'd3 || stall_cnt !== 16'd5) begin
      n_err++;
      $display("FAIL cnt_sat got %0d/%0d exp 3/5",
               b_cnt, stall_cnt);
    end
    drive(5'd4, 5'd6, 1'b1, 5'd6, 1'b0,
          1'b0, 1'b0, 1'b1);
    tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (b_cnt !== 2'd0 || stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL cnt_clr got %0d/%0d exp 0/0",
               b_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0,
          1'b1, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if (obs1() !== 26'b00000_111_0_0000000000000000_0) begin
      n_err++;
      $display("FAIL async_reset got %b exp %b",
               obs1(), 26'b00000_111_0_0000000000000000_0);
    end
    tick();
    reset = 1'b1;
    idle();
    @(negedge clk);
    n_vec++;
    if (obs1() !== exp1()) begin
      n_err++;
      $display("FAIL async_release got %b exp %b",
               obs1(), exp1());
    end
    tick();
  endtask

  task automatic test_random();
    logic rq;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      rq = mw ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      drive(5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 4) == 0),
            rq,
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 29) == 0));
      @(negedge clk);
      x1 = exp1(); g1 = obs1();
      n_vec++;
      if (g1 !== x1) begin
        n_err++;
        $display("FAIL rand%0d got %b exp %b",
                 i, g1, x1);
      end
      x2 = exp2(); g2 = obs2();
      n_vec++;
      if (g2 !== x2) begin
        n_err++;
        $display("FAIL rand2_%0d got %b exp %b",
                 i, g2, x2);
      end
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_zero_wait();
    test_simultaneous();
    test_counter();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Pipeline sequencing controller for the 5-stage MIPS pipeline. Drives the load-enable and synchronous-clear controls of the 32-bit pipeline/PC registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Handles three cases:
- load-use stalls,
- taken-branch flushes,
- a variable-latency data-memory handshake that freezes the pipeline.

It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- ex_memread  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ack  in  1  data memory completes the access this cycle
- clr_cnt  in  1  synchronous clear of stall_cnt
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load NOP (zero) instead of data; only effective when the matching en is 1
- state  out  1  0 = RUN, 1 = MEMWAIT
- stall_cnt  out  CNT_W  count of cycles with pc_en = 0

## Operation
- **FSM states.** RUN and MEMWAIT. Reset value is RUN.
- **Transitions.**
  - RUN → MEMWAIT when mem_req=1 and mem_ack=0.
  - MEMWAIT → RUN when mem_ack=1.
  - Otherwise the state holds.
- **Mem-stall condition.**
  - Active when (RUN and mem_req=1 and mem_ack=0) or (MEMWAIT and mem_ack=0).
  - Outputs: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_en=1 with memwb_flush=1, so WB gets a bubble and no writeback repeats.
  - All other flushes are 0.
  - ex_branch_taken and the load-use check are ignored while stalled.
- **Advance cycle.** When there is no mem-stall (including MEMWAIT with mem_ack=1, and RUN with mem_req and mem_ack both 1), the following priority applies:
  1. **Branch taken** (ex_branch_taken=1):
     - all en = 1, with ifid_flush=1 and idex_flush=1;
     - PC loads the branch target;
     - the load-use check is suppressed.
  2. **Load-use:**
     - condition: ex_memread=1, ex_rt≠0, and (ex_rt==id_rs or ex_rt==id_rt);
     - pc_en=0 and ifid_en=0;
     - idex_en=1 with idex_flush=1;
     - exmem_en=1 and memwb_en=1, no other flush.
  3. **Normal:** all en=1, all flush=0.
- **Output type.** Outputs are combinational (Mealy) functions of the state and the current inputs. No output is registered except state and stall_cnt.
- **Stall counter.**
  - On each rising edge: if clr_cnt=1, stall_cnt ← 0 (clear wins).
  - Else if pc_en=0 and stall_cnt≠all-ones, stall_cnt ← stall_cnt+1.
  - It saturates at 2^CNT_W−1 and never wraps.
- **While reset=0:**
  - state=RUN and stall_cnt=0;
  - all en outputs forced 0;
  - ifid_flush, idex_flush and memwb_flush forced 1.
  - Reset mid-MEMWAIT abandons the wait. The memory side is reset by the same signal.

## Timing
- **Latency.**
  - Load-use stall: exactly 1 cycle.
  - Branch: costs 2 bubble slots, via the IF/ID and ID/EX flush in the same cycle.
- **Memory stall.**
  - A zero-wait access (mem_ack in the same cycle as the first mem_req) causes no stall.
  - An N-cycle wait, with ack arriving N cycles after the first req, freezes the pipeline for exactly N cycles, with state=MEMWAIT for N−1 of them. The pipeline advances on the ack cycle.
- **Handshake rules.**
  - mem_req must stay high until mem_ack.
  - mem_ack without mem_req in RUN is ignored.
  - mem_req seen the cycle after an ack belongs to the next instruction.
- **Reset timing.** Reset assertion takes effect immediately, asynchronously. Release is synchronous to the next rising edge; the first cycle after release is RUN with normal decode.

## Test plan
- **Reset:** hold reset=0 for 3 cycles, with mem_req=1 and the load-use condition true. Required: all en=0, all three flush=1, state=0, stall_cnt=0. After release with idle inputs: all en=1, all flush=0.
- **Load-use:** ex_memread=1, ex_rt=5, id_rs=5, mem_req=0 for 1 cycle. Required: pc_en=0, ifid_en=0, idex_flush=1, stall_cnt 0→1. Same stimulus with ex_rt=0: no stall.
- **Memory wait:** mem_req=1 held, mem_ack=1 on the 4th cycle. Required:
  - cycles 1–3: stall outputs, with memwb_flush=1;
  - state=1 in cycles 2–3;
  - cycle 4: all en=1;
  - state returns to 0 and stall_cnt=3.
- **Zero-wait:** mem_req=1 and mem_ack=1 in the same cycle. Required: no stall, state stays 0.
- **Simultaneous events:**
  - ex_branch_taken=1 with load-use true: flush only, pc_en=1.
  - ex_branch_taken=1 during MEMWAIT with mem_ack=0: stall outputs only.
  - Branch held through the ack cycle: flush applied on that cycle.
- **Counter:** CNT_W=2 with 5 consecutive load-use cycles → stall_cnt saturates at 3. Then clr_cnt=1 together with a stall → stall_cnt=0.
